dff_bank_arbiter: RTL and testbench
===================================

Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared W-bit D-flip-flop register.
- NREQ requesters each present data and raise a request. The block picks one winner, loads that winner's data into the register and returns a one-cycle grant.
- After each load it enforces a programmable hold window before the next load.
- Sits between multiple producers and a single registered storage element in the DFF datapath.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- W, 8: register data width.
- HOLD, 2: cycles the register is held (no new load) after each load, 0..255.

Ports:
- C  input  1  clock; all state updates on the rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- REQ  input  NREQ  per-requester write request, level-sensitive.
- D  input  NREQ*W  requester i data at bits [i*W +: W].
- GNT  output  NREQ  one-hot grant pulse, registered.
- Q  output  W  shared register contents.
- OWNER  output  clog2(NREQ)  index of the last granted requester.
- VALID  output  1  high once Q has been loaded at least once since reset.
- BUSY  output  1  high during the hold window.

Behaviour:
- Reset (CLR_N=0, asynchronous, takes effect immediately, even mid-HOLD):
  - Q=0, GNT=0, OWNER=0, VALID=0, BUSY=0.
  - Priority pointer ptr=NREQ-1, so requester 0 wins first.
  - Hold counter=0, state=IDLE.
- Reset release is synchronous to C. Arbitration resumes on the first rising edge with CLR_N=1.
- State IDLE:
  - If REQ has no bits set: GNT=0 next cycle, stay in IDLE.
  - If REQ has any bit set, winner = first index with REQ set, searching ptr+1, ptr+2, ... modulo NREQ.
  - On that edge: Q<=D[winner], GNT<=one-hot(winner), OWNER<=winner, VALID<=1, ptr<=winner.
  - If HOLD>0: go to HOLD, counter<=HOLD-1, BUSY<=1.
  - If HOLD==0: stay in IDLE. Back-to-back grants are then possible every cycle.
- State HOLD:
  - GNT=0; REQ and D are ignored; Q is unchanged.
  - If counter==0: go to IDLE with BUSY<=0. Otherwise counter decrements.
  - BUSY is high for exactly HOLD cycles after the grant cycle.
- Latency and grant timing:
  - REQ sampled at edge k produces GNT and the new Q after edge k. GNT and the new Q are visible in the same cycle.
  - GNT is high for exactly one cycle per load. At most one GNT bit is ever set.
- Requester handshake:
  - A requester holds REQ and D stable until it sees its GNT bit, then deasserts REQ in that same cycle.
  - If REQ is still high on the next eligible edge, the requester re-competes. It now has lowest priority because it is the current ptr.
- Boundary conditions:
  - REQ withdrawn before grant: no grant, no error, no state change.
  - Single persistent requester: granted every HOLD+1 cycles.
  - All requesters persistent: strict rotation 0,1,…,NREQ-1,0, one grant per HOLD+1 cycles.
  - ptr wraps from NREQ-1 to 0.
  - OWNER and VALID hold their values through HOLD and idle periods until the next grant or reset.
- Width rules:
  - OWNER width = clog2(NREQ).
  - Counter width = clog2(HOLD+1), minimum 1 bit.

Test Plan:
- Reset: drive random REQ/D, then pulse CLR_N=0 between clock edges -> Q=0x00, GNT=0000, OWNER=0, VALID=0, BUSY=0 immediately, without waiting for an edge.
- Single request (NREQ=4, W=8, HOLD=2): REQ=0100, D2=0xA5, drop REQ on GNT -> after the next edge GNT=0100 for 1 cycle, Q=0xA5, OWNER=2, VALID=1, BUSY=1 for 2 cycles then 0.
- Rotation: REQ=1111 held, Di=0x10+i -> grants 0,1,2,3,0 at 3-cycle spacing, with Q=0x10,0x11,0x12,0x13,0x10 and OWNER following.
- HOLD=0 build: REQ=1010 held -> GNT alternates 0010,1000,0010 on consecutive cycles; BUSY stays 0.
- Withdrawal during HOLD: REQ0 and REQ3 raised, requester 0 granted, REQ3 dropped while BUSY=1 -> no further grant; state returns to IDLE with GNT=0000 and Q unchanged.
- Reset mid-HOLD: assert CLR_N=0 while BUSY=1, release, then raise REQ=1111 -> BUSY=0 and Q=0 at once; first grant goes to requester 0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter that loads one requester's data into a shared W-bit register,
// then blocks further loads for HOLD cycles.
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic                       C,
  input  logic                       CLR_N,
  input  logic [NREQ-1:0]            REQ,
  input  logic [NREQ*W-1:0]          D,
  output logic [NREQ-1:0]            GNT,
  output logic [W-1:0]               Q,
  output logic [$clog2(NREQ)-1:0]    OWNER,
  output logic                       VALID,
  output logic                       BUSY
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = HOLD > 0 ? $clog2(HOLD + 1) : 1;
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [OW-1:0]   r_ptr, r_owner, w_win;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [W-1:0]    r_q;
  logic            r_valid, w_load;
  // scan downwards so the nearest requester after r_ptr is the last one written
  always_comb begin
    logic [OW-1:0] idx;
    idx   = '0;
    w_win = r_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OW'((int'(r_ptr) + k) % NREQ);
      if (REQ[idx]) w_win = idx;
    end
  end
  assign w_load = r_state == S_IDLE && |REQ;
  always_comb begin
    w_state_nxt = w_load ? (HOLD > 0 ? S_HOLD : S_IDLE)
                         : (r_state == S_HOLD && r_cnt != '0 ? S_HOLD : S_IDLE);
    w_cnt_nxt   = w_load ? CW'(HOLD > 0 ? HOLD - 1 : 0)
                         : (r_cnt != '0 ? r_cnt - CW'(1) : r_cnt);
  end
  always_comb begin
    w_gnt_nxt = w_load ? NREQ'(1) << w_win : '0;
  end
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= OW'(NREQ - 1);
      r_owner <= '0;
      r_gnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_load) begin
        r_q     <= D[w_win*W +: W];
        r_ptr   <= w_win;
        r_owner <= w_win;
        r_valid <= 1'b1;
      end
    end
  end
  assign GNT   = r_gnt;
  assign Q     = r_q;
  assign OWNER = r_owner;
  assign VALID = r_valid;
  assign BUSY  = r_state == S_HOLD;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and random checks of a HOLD=2 and a HOLD=0 instance sharing inputs,
// against a queue-free behavioural model of the arbitration rules.
module tb_dff_bank_arbiter;
  localparam int N = 4;
  logic        C = 1'b0, CLR_N = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] D = '0;
  logic [3:0]  g0, g1;
  logic [7:0]  q0, q1;
  logic [1:0]  o0, o1;
  logic        v0, v1, b0, b1;
  int          n_cmp = 0, n_err = 0;
  int          m_ptr[2], m_left[2], m_own[2];
  int          m_hold[2] = '{2, 0};
  logic [7:0]  m_q[2];
  logic        m_val[2];
  logic [3:0]  m_gnt[2];

  always #5 C = ~C;

  dff_bank_arbiter #(.NREQ(4), .W(8), .HOLD(2)) u_dut0 (
    .C(C), .CLR_N(CLR_N), .REQ(REQ), .D(D),
    .GNT(g0), .Q(q0), .OWNER(o0), .VALID(v0), .BUSY(b0));
  dff_bank_arbiter #(.NREQ(4), .W(8), .HOLD(0)) u_dut1 (
    .C(C), .CLR_N(CLR_N), .REQ(REQ), .D(D),
    .GNT(g1), .Q(q1), .OWNER(o1), .VALID(v1), .BUSY(b1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_ptr[n] = N - 1; m_left[n] = 0; m_own[n] = 0;
      m_q[n] = '0; m_val[n] = 1'b0; m_gnt[n] = '0;
    end
  endtask

  task automatic model_step(input logic [3:0] req, input logic [31:0] d);
    for (int n = 0; n < 2; n++) begin
      m_gnt[n] = '0;
      if (m_left[n] > 0) m_left[n]--;
      else if (req != 0) begin
        int w, idx;
        w = -1;
        for (int k = 1; k <= N && w < 0; k++) begin
          idx = (m_ptr[n] + k) % N;
          if (req[idx[1:0]]) w = idx;
        end
        m_gnt[n]  = 4'(1 << w);
        m_q[n]    = d[w*8 +: 8];
        m_own[n]  = w;
        m_val[n]  = 1'b1;
        m_ptr[n]  = w;
        m_left[n] = m_hold[n];
      end
    end
  endtask

  task automatic compare_all();
    check("gnt0", 32'(g0), 32'(m_gnt[0]));
    check("q0", 32'(q0), 32'(m_q[0]));
    check("owner0", 32'(o0), 32'(m_own[0]));
    check("valid0", 32'(v0), 32'(m_val[0]));
    check("busy0", 32'(b0), 32'(m_left[0] > 0));
    check("gnt1", 32'(g1), 32'(m_gnt[1]));
    check("q1", 32'(q1), 32'(m_q[1]));
    check("owner1", 32'(o1), 32'(m_own[1]));
    check("valid1", 32'(v1), 32'(m_val[1]));
    check("busy1", 32'(b1), 32'(m_left[1] > 0));
  endtask

  task automatic cyc(input logic [3:0] req, input logic [31:0] d);
    @(negedge C);
    REQ = req;
    D   = d;
    model_step(req, d);
    @(posedge C);
    #1;
    compare_all();
  endtask

  // reset is asserted between edges and the outputs are checked before any edge arrives
  task automatic async_reset();
    #2;
    CLR_N = 1'b0;
    #1;
    check("rst_gnt", 32'(g0), 32'd0);
    check("rst_q", 32'(q0), 32'd0);
    check("rst_owner", 32'(o0), 32'd0);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);
    model_reset();
    compare_all();
    @(negedge C);
    CLR_N = 1'b1;
    REQ   = '0;
    model_step(4'b0, D);
  endtask

  initial begin
    logic [31:0] d, pd;
    logic [3:0]  p;
    int          busy_exp[3];
    busy_exp = '{1, 1, 0};
    REQ = 4'($urandom);
    D   = $urandom;
    @(posedge C);
    #1;
    async_reset();

    // single request from requester 2
    d = $urandom;
    d[23:16] = 8'hA5;
    cyc(4'b0100, d);
    check("single_gnt", 32'(g0), 32'h4);
    check("single_q", 32'(q0), 32'hA5);
    check("single_owner", 32'(o0), 32'd2);
    check("single_valid", 32'(v0), 32'd1);
    check("single_busy_0", 32'(b0), 32'(busy_exp[0]));
    for (int c = 1; c < 3; c++) begin
      cyc(4'b0000, d);
      check("single_gnt_off", 32'(g0), 32'd0);
      check("single_busy", 32'(b0), 32'(busy_exp[c]));
    end

    // all requesters persistent: strict rotation every HOLD+1 cycles
    async_reset();
    for (int c = 0; c < 15; c++) begin
      cyc(4'b1111, 32'h13121110);
      if (c % 3 == 0) begin
        check("rot_owner", 32'(o0), 32'((c / 3) % 4));
        check("rot_q", 32'(q0), 32'(8'h10 + (c / 3) % 4));
      end
    end

    // HOLD=0 instance alternates on consecutive cycles
    async_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(4'b1010, $urandom);
      check("h0_gnt", 32'(g1), (c % 2) ? 32'h8 : 32'h2);
      check("h0_busy", 32'(b1), 32'd0);
    end

    // requester 3 withdraws while the register is held
    async_reset();
    d = $urandom;
    cyc(4'b1001, d);
    check("wd_gnt", 32'(g0), 32'h1);
    cyc(4'b1000, d);
    cyc(4'b0000, d);
    cyc(4'b0000, d);
    check("wd_gnt_off", 32'(g0), 32'd0);
    check("wd_q", 32'(q0), 32'(d[7:0]));
    check("wd_busy", 32'(b0), 32'd0);

    // reset during the hold window, then full contention restarts at requester 0
    cyc(4'b0001, $urandom);
    check("mh_busy", 32'(b0), 32'd1);
    async_reset();
    cyc(4'b1111, $urandom);
    check("mh_owner", 32'(o0), 32'd0);
    check("mh_gnt", 32'(g0), 32'h1);

    // random handshaking requesters with occasional withdrawal and reset
    p  = '0;
    pd = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (p[i] && g0[i]) p[i] = 1'b0;
        else if (!p[i] && $urandom_range(0, 2) == 0) begin
          p[i] = 1'b1;
          pd[i*8 +: 8] = 8'($urandom);
        end else if (p[i] && $urandom_range(0, 15) == 0) p[i] = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        p = '0;
      end
      cyc(p, pd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
